// File: rtl/proc_pipe_pckg.sv
// Shared processing-pipe package: vector geometry, memory sizing and the
// state type of the stream-to-memory writer.
// Optional feature macro: STREAM_MEM_WR_ZERO_FILL_EN (adds the FILL state).
package proc_pipe_pckg;

    // Geometry of one pipe data vector.
    localparam int C_VECT_SIZE         = 4;
    localparam int C_INT_DATA_WORD_WDT = 16;
    localparam int C_VECT_WDT          = C_VECT_SIZE * C_INT_DATA_WORD_WDT;

    // On-chip vector memory sizing; the length counter needs one extra bit
    // so a full 2^ADDR_WDT-vector transfer can be expressed.
    localparam int C_MEM_ADDR_WDT = 12;
    localparam int C_VECT_LEN_WDT = C_MEM_ADDR_WDT + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_DRAIN = 3'd2,
`ifdef STREAM_MEM_WR_ZERO_FILL_EN
        ST_FILL  = 3'd3,
`endif
        ST_DONE  = 3'd4
    } stream_mem_wr_state_t;

endpackage

// File: rtl/stream_mem_wr_addr_gen.sv
// Address generator for stream_mem_wr: latches the base address and the
// expected vector count at start, counts written vectors and produces the
// wrap-around write address base + count (modulo 2^ADDR_WDT).
module stream_mem_wr_addr_gen
    import proc_pipe_pckg::*;
#(
    parameter int ADDR_WDT = C_MEM_ADDR_WDT,
    parameter int LEN_WDT  = C_VECT_LEN_WDT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ADDR_WDT-1:0] base_addr,
    input  logic [LEN_WDT-1:0]  vect_len,
    input  logic                inc,
    output logic [ADDR_WDT-1:0] addr,
    output logic [LEN_WDT-1:0]  cnt,
    output logic                cnt_at_last
);

    logic [ADDR_WDT-1:0] base_q;
    logic [LEN_WDT-1:0]  len_q;
    logic [LEN_WDT-1:0]  cnt_q;

    // Base/length latch at start and the running write counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking
        // assignments so every register samples pre-edge values.
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            base_q <= base_addr;
            len_q  <= vect_len;
            cnt_q  <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + LEN_WDT'(1);
        end
    end

    // Address wraps naturally through the ADDR_WDT-bit adder.
    assign addr        = base_q + cnt_q[ADDR_WDT-1:0];
    assign cnt         = cnt_q;
    // True when the vector being written now is the last one expected.
    assign cnt_at_last = ((cnt_q + LEN_WDT'(1)) == len_q);

endmodule

// File: rtl/stream_mem_wr.sv
// stream_mem_wr: consumes pipe data vectors from the AXI-Stream slave and
// writes them to vector memory at consecutive addresses from a programmed
// base, then reports completion and length errors through start/done.
// Optional feature macro: STREAM_MEM_WR_ZERO_FILL_EN -- on a short stream
// the remaining addresses are filled with zero vectors before done.
// The start handshake is a control-side pulse and is taken regardless of
// clk_en; the done pulse is likewise independent of clk_en.
module stream_mem_wr
    import proc_pipe_pckg::*;
#(
    parameter int VECT_WDT = C_VECT_WDT,
    parameter int ADDR_WDT = C_MEM_ADDR_WDT,
    parameter int LEN_WDT  = C_VECT_LEN_WDT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                en,
    input  logic                start,
    input  logic [ADDR_WDT-1:0] base_addr,
    input  logic [LEN_WDT-1:0]  vect_len,
    input  logic                in_vect_val,
    input  logic                in_vect_last,
    input  logic [VECT_WDT-1:0] in_vect_words,
    output logic                mem_wr_en,
    output logic [ADDR_WDT-1:0] mem_addr,
    output logic [VECT_WDT-1:0] mem_wr_data,
    output logic                busy,
    output logic                done,
    output logic                err_short,
    output logic                err_long,
    output logic [LEN_WDT-1:0]  wr_cnt
);

    stream_mem_wr_state_t state_q, state_nxt;

    logic                accept;
    logic                load;
    logic                inc;
    logic                wr_fire;
    logic                wr_zero;
    logic                set_short;
    logic                set_long;
    logic [ADDR_WDT-1:0] gen_addr;
    logic                cnt_at_last;

    assign accept = clk_en & in_vect_val;

    stream_mem_wr_addr_gen #(
        .ADDR_WDT (ADDR_WDT),
        .LEN_WDT  (LEN_WDT)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .base_addr   (base_addr),
        .vect_len    (vect_len),
        .inc         (inc),
        .addr        (gen_addr),
        .cnt         (wr_cnt),
        .cnt_at_last (cnt_at_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt = state_q;
        load      = 1'b0;
        inc       = 1'b0;
        wr_fire   = 1'b0;
        wr_zero   = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Incoming vectors are dropped here.
                if (start && en) begin
                    load      = 1'b1;
                    state_nxt = (vect_len == '0) ? ST_DRAIN : ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (accept) begin
                    wr_fire = 1'b1;
                    inc     = 1'b1;
                    if (in_vect_last) begin
                        if (cnt_at_last) begin
                            state_nxt = ST_DONE;
                        end else begin
                            set_short = 1'b1;
`ifdef STREAM_MEM_WR_ZERO_FILL_EN
                            state_nxt = ST_FILL;
`else
                            state_nxt = ST_DONE;
`endif
                        end
                    end else if (cnt_at_last) begin
                        set_long  = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Surplus vectors are consumed without writing; any
                // non-last vector here means the stream is too long.
                if (accept) begin
                    if (in_vect_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        set_long = 1'b1;
                    end
                end
            end

`ifdef STREAM_MEM_WR_ZERO_FILL_EN
            ST_FILL: begin
                // One zero vector per pipeline step until the count is met.
                if (clk_en) begin
                    wr_fire = 1'b1;
                    wr_zero = 1'b1;
                    inc     = 1'b1;
                    if (cnt_at_last) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
`endif

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered memory write port, status flags and handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: the write-data register is reset because it is a port that
        // must read 0 out of reset; the memory array behind it is not.
        if (rst) begin
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            mem_wr_en <= wr_fire;
            done      <= (state_q == ST_DONE);

            if (wr_fire) begin
                mem_addr    <= gen_addr;
                mem_wr_data <= wr_zero ? '0 : in_vect_words;
            end

            if (load) begin
                busy      <= 1'b1;
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end else begin
                if (state_q == ST_DONE) begin
                    busy <= 1'b0;
                end
                if (set_short) begin
                    err_short <= 1'b1;
                end
                if (set_long) begin
                    err_long <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mem_wr.sv
// Self-checking bench for stream_mem_wr. A transfer-level model schedules,
// per clock, the expected memory writes, done pulse and busy window from
// the vectors the bench drives; one compare process checks every cycle.
module tb_stream_mem_wr;
    import proc_pipe_pckg::*;

    localparam int VW = C_VECT_WDT;
    localparam int AW = C_MEM_ADDR_WDT;
    localparam int LW = C_VECT_LEN_WDT;
`ifdef STREAM_MEM_WR_ZERO_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] vect_len = '0;
    logic          in_vect_val = 1'b0;
    logic          in_vect_last = 1'b0;
    logic [VW-1:0] in_vect_words = '0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [VW-1:0] mem_wr_data;
    logic          busy;
    logic          done;
    logic          err_short;
    logic          err_long;
    logic [LW-1:0] wr_cnt;

    stream_mem_wr dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .en            (en),
        .start         (start),
        .base_addr     (base_addr),
        .vect_len      (vect_len),
        .in_vect_val   (in_vect_val),
        .in_vect_last  (in_vect_last),
        .in_vect_words (in_vect_words),
        .mem_wr_en     (mem_wr_en),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .busy          (busy),
        .done          (done),
        .err_short     (err_short),
        .err_long      (err_long),
        .wr_cnt        (wr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Transfer-level model state.
    logic [AW+VW-1:0] exp_wr [int];
    int            exp_done_key = -1;
    int            busy_lo = 0;
    int            busy_hi = 0;
    bit            chk_on = 1'b0;
    bit            xfer_open = 1'b0;
    logic [AW-1:0] cur_base;
    int            cur_len;
    int            acc_cnt;
    int            exp_cnt;
    bit            exp_short;
    bit            exp_long;

    logic [AW-1:0] wr_addr_log[$];
    int            wr_key_log[$];
    int            done_seen = -1;

    // Per-cycle comparison against the scheduled expectations.
    always @(negedge clk) begin
        if (chk_on) begin
            check("mem_wr_en", 64'(mem_wr_en), 64'(exp_wr.exists(cyc) != 0));
            if (exp_wr.exists(cyc) != 0 && mem_wr_en) begin
                check("mem_addr", 64'(mem_addr), 64'(exp_wr[cyc][AW+VW-1:VW]));
                check("mem_wr_data", 64'(mem_wr_data), 64'(exp_wr[cyc][VW-1:0]));
            end
            check("done", 64'(done), 64'(cyc == exp_done_key));
            check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc < busy_hi));
            if (mem_wr_en) begin
                wr_addr_log.push_back(mem_addr);
                wr_key_log.push_back(cyc);
            end
            if (done) done_seen = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] mk(input int t, input int i);
        return VW'(64'hC0DE_0000_0000_0000 | (64'(t) << 16) | 64'(i + 1));
    endfunction

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_key_log.delete();
        done_seen = -1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int l);
        base_addr = b;
        vect_len  = LW'(l);
        en        = 1'b1;
        start     = 1'b1;
        busy_lo   = cyc + 1;
        busy_hi   = 1 << 30;
        step();
        start     = 1'b0;
        cur_base  = b;
        cur_len   = l;
        acc_cnt   = 0;
        xfer_open = 1'b1;
    endtask

    // Drive one cycle of stream input and schedule what it must cause.
    task automatic send(input bit val, input bit last, input logic [VW-1:0] w, input bit ce);
        int key;
        int fill_n;
        in_vect_val   = val;
        in_vect_last  = last;
        in_vect_words = w;
        clk_en        = ce;
        if (ce && val && xfer_open) begin
            key = cyc + 1;
            if (acc_cnt < cur_len)
                exp_wr[key] = {cur_base + AW'(acc_cnt), w};
            acc_cnt++;
            if (last) begin
                xfer_open = 1'b0;
                fill_n = (FILL && acc_cnt < cur_len) ? cur_len - acc_cnt : 0;
                for (int j = 0; j < fill_n; j++)
                    exp_wr[key + 1 + j] = {cur_base + AW'(acc_cnt + j), {VW{1'b0}}};
                exp_done_key = key + 1 + fill_n;
                busy_hi      = exp_done_key;
                exp_cnt      = (fill_n > 0) ? cur_len : ((acc_cnt < cur_len) ? acc_cnt : cur_len);
                exp_short    = (acc_cnt < cur_len);
                exp_long     = (cur_len == 0) ? (acc_cnt > 1) : (acc_cnt > cur_len);
            end
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic check_result(input string tag);
        check({tag, " wr_cnt"}, 64'(wr_cnt), 64'(exp_cnt));
        check({tag, " err_short"}, 64'(err_short), 64'(exp_short));
        check({tag, " err_long"}, 64'(err_long), 64'(exp_long));
        check({tag, " done seen"}, 64'(done_seen), 64'(exp_done_key));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst mem_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst errs", 64'({err_short, err_long}), 64'd0);
        check("rst wr_cnt", 64'(wr_cnt), 64'd0);
        step();
        rst    = 1'b0;
        chk_on = 1'b1;
        step();

        // T1: base 0x010, len 4; a vector coinciding with start is dropped,
        // a start while busy is ignored.
        clear_logs();
        in_vect_val = 1'b1; in_vect_words = mk(9, 9);
        do_start(AW'(12'h010), 4);
        send(1, 0, mk(1, 0), 1);
        start = 1'b1; base_addr = AW'(12'h300);
        send(1, 0, mk(1, 1), 1);
        start = 1'b0;
        send(1, 0, mk(1, 2), 1);
        send(1, 1, mk(1, 3), 1);
        idle(4);
        check_result("t1");
        check("t1 nwrites", 64'(wr_addr_log.size()), 64'd4);
        check("t1 addr0", 64'(wr_addr_log[0]), 64'h010);
        check("t1 addr3", 64'(wr_addr_log[3]), 64'h013);
        check("t1 done after last write", 64'(done_seen - wr_key_log[3]), 64'd1);
        check("t1 wr_cnt lit", 64'(wr_cnt), 64'd4);

        // T2: address wrap; start together with the final vector is ignored.
        clear_logs();
        do_start(AW'(12'hFFE), 4);
        for (int i = 0; i < 3; i++) send(1, 0, mk(2, i), 1);
        start = 1'b1;
        send(1, 1, mk(2, 3), 1);
        start = 1'b0;
        idle(4);
        check_result("t2");
        check("t2 addr0", 64'(wr_addr_log[0]), 64'hFFE);
        check("t2 addr1", 64'(wr_addr_log[1]), 64'hFFF);
        check("t2 addr2", 64'(wr_addr_log[2]), 64'h000);
        check("t2 addr3", 64'(wr_addr_log[3]), 64'h001);
        check("t2 busy after", 64'(busy), 64'd0);

        // T3: short stream, last on the 2nd of 4.
        clear_logs();
        do_start(AW'(12'h100), 4);
        send(1, 0, mk(3, 0), 1);
        send(1, 1, mk(3, 1), 1);
        idle(6);
        check_result("t3");
        check("t3 err_short lit", 64'(err_short), 64'd1);
        check("t3 wr_cnt lit", 64'(wr_cnt), FILL ? 64'd4 : 64'd2);
        check("t3 nwrites lit", 64'(wr_addr_log.size()), FILL ? 64'd4 : 64'd2);

        // T4: long stream, len 2 with 5 vectors.
        clear_logs();
        do_start(AW'(12'h200), 2);
        for (int i = 0; i < 5; i++) send(1, i == 4, mk(4, i), 1);
        idle(4);
        check_result("t4");
        check("t4 err_long lit", 64'(err_long), 64'd1);
        check("t4 nwrites lit", 64'(wr_addr_log.size()), 64'd2);
        check("t4 wr_cnt lit", 64'(wr_cnt), 64'd2);

        // T5: clk_en toggling with valid held high; then a vector in IDLE.
        clear_logs();
        do_start(AW'(12'h040), 3);
        for (int i = 0; i < 6; i++) send(1, i == 4, mk(5, i), (i % 2) == 0);
        idle(3);
        send(1, 1, mk(5, 7), 1);
        idle(2);
        check_result("t5");
        check("t5 nwrites lit", 64'(wr_addr_log.size()), 64'd3);
        check("t5 spacing a", 64'(wr_key_log[1] - wr_key_log[0]), 64'd2);
        check("t5 spacing b", 64'(wr_key_log[2] - wr_key_log[1]), 64'd2);
        check("t5 addr2", 64'(wr_addr_log[2]), 64'h042);

        // T6: zero length, first vector is last alone -> no error.
        clear_logs();
        do_start(AW'(12'h050), 0);
        send(1, 1, mk(6, 0), 1);
        idle(3);
        check_result("t6");
        check("t6 no err_long", 64'(err_long), 64'd0);

        // T7: reset mid-WRITE after 1 of 3 vectors.
        clear_logs();
        do_start(AW'(12'h005), 3);
        send(1, 0, mk(7, 0), 1);
        in_vect_val  = 1'b0;
        rst          = 1'b1;
        busy_hi      = cyc + 1;
        exp_done_key = -1;
        xfer_open    = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t7 mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("t7 mem_addr", 64'(mem_addr), 64'd0);
        check("t7 mem_wr_data", 64'(mem_wr_data), 64'd0);
        check("t7 wr_cnt", 64'(wr_cnt), 64'd0);
        check("t7 busy", 64'(busy), 64'd0);
        step();
        idle(3);
        check("t7 no done", 64'(done_seen), 64'hFFFF_FFFF_FFFF_FFFF);

        // T8: normal single-vector transfer after the reset.
        clear_logs();
        do_start(AW'(12'h020), 1);
        send(1, 1, mk(8, 0), 1);
        idle(3);
        check_result("t8");
        check("t8 addr", 64'(wr_addr_log[0]), 64'h020);
        check("t8 wr_cnt lit", 64'(wr_cnt), 64'd1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
